// File: rtl/incr_pipe.sv
// incr_pipe: elastic pipeline that adds in_step to in_data.
// The sum is formed once, at acceptance; the stages only carry the result.
// The result either wraps or clamps to all-ones. The carry travels
// alongside the result as out_ovf. Bubbles collapse, so STAGES beats fit
// in the pipe while the output is stalled.
module incr_pipe #(
  parameter int WIDTH    = 8,
  parameter int STAGES   = 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_step,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] ovf_q, ovf_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [STAGES-1:0] load_s;
  logic [WIDTH:0]    sum_s;
  logic [WIDTH-1:0]  result_s;
  logic              carry_s;
  logic              accept_s;
  logic              run_q, run_d;

  // Load chain: a stage may load when it is empty or every stage after it can move
  always_comb begin
    logic chain_v;
    chain_v = out_ready;
    load_s  = {STAGES{1'b0}};
    for (int k = STAGES - 1; k >= 0; k--) begin
      chain_v   = chain_v | ~valid_q[k];
      load_s[k] = chain_v;
    end
  end

  // Widened add at acceptance; the carry is the overflow flag, and saturation only affects the data
  always_comb begin
    sum_s   = {1'b0, in_data} + {1'b0, in_step};
    carry_s = sum_s[WIDTH];
    if (SATURATE && carry_s) begin
      result_s = {WIDTH{1'b1}};
    end else begin
      result_s = sum_s[WIDTH-1:0];
    end
  end

  // Input is held off during reset, until the first edge after release, and while flushing
  assign in_ready = load_s[0] & ~flush & run_q;
  assign accept_s = in_valid & in_ready;

  // Next state for every stage; a flush drops all valid bits after any output transfer on that edge
  always_comb begin
    run_d = 1'b1;
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k] = valid_q[k] & ~flush;
      ovf_d[k]   = ovf_q[k];
      data_d[k]  = data_q[k];
    end
    if (load_s[0]) begin
      valid_d[0] = accept_s;
      ovf_d[0]   = carry_s;
      data_d[0]  = result_s;
    end else begin
      valid_d[0] = valid_q[0] & ~flush;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (load_s[k]) begin
        valid_d[k] = valid_q[k-1] & ~flush;
        ovf_d[k]   = ovf_q[k-1];
        data_d[k]  = data_q[k-1];
      end else begin
        valid_d[k] = valid_q[k] & ~flush;
      end
    end
  end

  // Stage registers, cleared asynchronously so outputs read zero during reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= {STAGES{1'b0}};
      ovf_q   <= {STAGES{1'b0}};
      run_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= {WIDTH{1'b0}};
      end
    end else begin
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      run_q   <= run_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_ovf   = ovf_q[STAGES-1];

endmodule
